// File: rtl/bp_fe_cmd_consumer_if.sv
// Handshake bundle between the FE command queue / icache and the FE command
// consumer. Signal names keep their consumer-side direction suffixes so they
// line up with the consumer's documentation.
//
// Command queue (valid/yumi):
//   fe_cmd_i       [113:0] head command; [3:0] opcode, [42:4] vaddr, [113:43] operand
//   fe_cmd_v_i             head command valid
//   fe_cmd_yumi_o          consumer dequeues the head this cycle
//
// Icache fence (valid/ready request, then a done pulse):
//   icache_fence_v_o       fence request valid
//   icache_fence_ready_i   icache accepts the request
//   icache_fence_done_i    fence complete pulse
//
// The handshake rules are as follows. The queue holds fe_cmd_i stable while
// fe_cmd_v_i is high until it sees fe_cmd_yumi_o. Yumi is only asserted
// together with valid. A fence request is accepted in a cycle where both
// icache_fence_v_o and icache_fence_ready_i are high.
interface bp_fe_cmd_consumer_if;
  logic [113:0] fe_cmd_i;
  logic         fe_cmd_v_i;
  logic         fe_cmd_yumi_o;
  logic         icache_fence_v_o;
  logic         icache_fence_ready_i;
  logic         icache_fence_done_i;

  // master: command queue + icache side
  modport master (
    output fe_cmd_i, fe_cmd_v_i, icache_fence_ready_i, icache_fence_done_i,
    input  fe_cmd_yumi_o, icache_fence_v_o
  );

  // slave: the command consumer
  modport slave (
    input  fe_cmd_i, fe_cmd_v_i, icache_fence_ready_i, icache_fence_done_i,
    output fe_cmd_yumi_o, icache_fence_v_o
  );
endinterface

// File: rtl/bp_fe_cmd_consumer.sv
// FE command consumer. It decodes the command at the head of the FE command
// queue without registering it. Simple commands are consumed in the same cycle
// they are seen. The icache fence and FE state-reset commands are sequenced by
// a small FSM. These commands are dequeued only when they finish.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   cmd_if (slave)          command queue + icache fence handshakes
//   redirect_v_o/pc_o       one-cycle PC redirect, target = vaddr
//   itlb_w_v_o/vtag_o/entry_o  one-cycle ITLB write
//   attaboy_v_o             one-cycle predictor confirm
//   fe_state_reset_o        FE state reset, held reset_cycles_p cycles
//   poison_o                one-cycle fetch pipeline flush
//   illegal_o               one-cycle pulse, unknown opcode consumed
//   timeout_o               sticky, an icache fence timed out
//   busy_o                  FSM not in IDLE
//   state_o                 current FSM state (debug)
module bp_fe_cmd_consumer #(
  parameter int reset_cycles_p  = 4,
  parameter int fence_timeout_p = 64
) (
  input  logic         clk_i,
  input  logic         reset_i,
  bp_fe_cmd_consumer_if.slave cmd_if,
  output logic         redirect_v_o,
  output logic [38:0]  redirect_pc_o,
  output logic         itlb_w_v_o,
  output logic [26:0]  itlb_w_vtag_o,
  output logic [70:0]  itlb_w_entry_o,
  output logic         attaboy_v_o,
  output logic         fe_state_reset_o,
  output logic         poison_o,
  output logic         illegal_o,
  output logic         timeout_o,
  output logic         busy_o,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {IDLE, FENCE_REQ, FENCE_WAIT, SRESET} state_e;

  localparam logic [7:0] fence_last_lp = 8'(fence_timeout_p - 1);
  localparam logic [7:0] sreset_last_lp = 8'(reset_cycles_p - 1);

  state_e     state_r;
  logic [7:0] cnt_r;
  logic       timeout_r;

  logic [3:0] opcode;
  logic       yumi_raw;
  logic       timeout_set;

  assign opcode = cmd_if.fe_cmd_i[3:0];

  // Data fields are plain slices of the queue head; the strobes qualify them.
  assign redirect_pc_o  = cmd_if.fe_cmd_i[42:4];
  assign itlb_w_vtag_o  = cmd_if.fe_cmd_i[42:16];
  assign itlb_w_entry_o = cmd_if.fe_cmd_i[113:43];

  // Strobes are combinational so simple commands retire in the cycle they are
  // seen. Everything is forced low while reset_i is high. This covers the
  // first reset cycle, when the state register still holds its old value.
  always_comb begin
    redirect_v_o            = 1'b0;
    itlb_w_v_o              = 1'b0;
    attaboy_v_o             = 1'b0;
    poison_o                = 1'b0;
    illegal_o               = 1'b0;
    fe_state_reset_o        = 1'b0;
    cmd_if.icache_fence_v_o = 1'b0;
    yumi_raw                = 1'b0;
    timeout_set             = 1'b0;
    if (!reset_i) begin
      case (state_r)
        IDLE: begin
          if (cmd_if.fe_cmd_v_i) begin
            case (opcode)
              4'd0: begin redirect_v_o = 1'b1; poison_o = 1'b1; yumi_raw = 1'b1; end
              4'd1: begin itlb_w_v_o   = 1'b1; yumi_raw = 1'b1; end
              4'd2: poison_o = 1'b1;
              4'd3: begin attaboy_v_o  = 1'b1; yumi_raw = 1'b1; end
              4'd4: poison_o = 1'b1;
              default: begin illegal_o = 1'b1; yumi_raw = 1'b1; end
            endcase
          end
        end
        FENCE_REQ: cmd_if.icache_fence_v_o = 1'b1;
        FENCE_WAIT: begin
          // done wins over a timeout landing in the same cycle
          if (cmd_if.icache_fence_done_i) begin
            yumi_raw = 1'b1;
          end else if (cnt_r == fence_last_lp) begin
            yumi_raw    = 1'b1;
            timeout_set = 1'b1;
          end
        end
        SRESET: begin
          fe_state_reset_o = 1'b1;
          if (cnt_r == sreset_last_lp) yumi_raw = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Never dequeue an empty queue head.
  assign cmd_if.fe_cmd_yumi_o = yumi_raw & cmd_if.fe_cmd_v_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      if (timeout_set) timeout_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (cmd_if.fe_cmd_v_i && opcode == 4'd2) begin
            state_r <= FENCE_REQ;
          end else if (cmd_if.fe_cmd_v_i && opcode == 4'd4) begin
            state_r <= SRESET;
            cnt_r   <= 8'd0;
          end
        end
        FENCE_REQ: begin
          if (cmd_if.icache_fence_ready_i) begin
            state_r <= FENCE_WAIT;
            cnt_r   <= 8'd0;
          end
        end
        FENCE_WAIT: begin
          if (cmd_if.icache_fence_done_i || cnt_r == fence_last_lp) begin
            state_r <= IDLE;
          end else if (cnt_r != 8'hff) begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        SRESET: begin
          if (cnt_r == sreset_last_lp) begin
            state_r <= IDLE;
          end else if (cnt_r != 8'hff) begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign timeout_o = timeout_r & ~reset_i;
  assign busy_o    = (state_r != IDLE) & ~reset_i;
  assign state_o   = state_r;

endmodule

// File: tb/tb_bp_fe_cmd_consumer.sv
// Self-checking bench for bp_fe_cmd_consumer. Each task builds a cycle table
// of inputs plus the expected strobe vector. It pushes each expected vector
// when it drives that cycle. It pops and compares the vector at the falling
// edge, where the combinational strobes have settled.
module tb_bp_fe_cmd_consumer;
  localparam int RC = 4;
  localparam int FT = 12;

  // expected-vector bit positions
  localparam logic [9:0] Y  = 10'h200, RD = 10'h100, PO = 10'h080, IT = 10'h040,
                         AT = 10'h020, FV = 10'h010, SR = 10'h008, IL = 10'h004,
                         TO = 10'h002, BZ = 10'h001;

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] op;
    logic       rdy;
    logic       done;
    logic [9:0] exp;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_fe_cmd_consumer_if bus();

  logic        redirect_v, itlb_w_v, attaboy_v, fe_state_reset, poison, illegal;
  logic        timeout, busy;
  logic [38:0] redirect_pc;
  logic [26:0] itlb_w_vtag;
  logic [70:0] itlb_w_entry;
  logic [1:0]  state;

  bp_fe_cmd_consumer #(.reset_cycles_p(RC), .fence_timeout_p(FT)) dut (
    .clk_i(clk), .reset_i(rst), .cmd_if(bus),
    .redirect_v_o(redirect_v), .redirect_pc_o(redirect_pc),
    .itlb_w_v_o(itlb_w_v), .itlb_w_vtag_o(itlb_w_vtag), .itlb_w_entry_o(itlb_w_entry),
    .attaboy_v_o(attaboy_v), .fe_state_reset_o(fe_state_reset), .poison_o(poison),
    .illegal_o(illegal), .timeout_o(timeout), .busy_o(busy), .state_o(state)
  );

  wire [9:0] obs = {bus.fe_cmd_yumi_o, redirect_v, poison, itlb_w_v, attaboy_v,
                    bus.icache_fence_v_o, fe_state_reset, illegal, timeout, busy};

  logic [9:0]  exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [38:0] cur_vaddr;
  logic [70:0] cur_operand;

  function automatic stim_t mk(input logic r, input logic v, input logic [3:0] op,
                               input logic rdy, input logic done, input logic [9:0] e);
    stim_t s;
    s.rst = r; s.v = v; s.op = op; s.rdy = rdy; s.done = done; s.exp = e;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst                      = s.rst;
    bus.fe_cmd_v_i           = s.v;
    bus.fe_cmd_i             = {cur_operand, cur_vaddr, s.op};
    bus.icache_fence_ready_i = s.rdy;
    bus.icache_fence_done_i  = s.done;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    stim_t s[$];
    logic [9:0] e;
    cur_vaddr = 39'h0; cur_operand = 71'h0;
    s.push_back(mk(1, 1, 4'd0, 1, 1, 10'h0));
    s.push_back(mk(1, 1, 4'd2, 1, 1, 10'h0));
    s.push_back(mk(0, 0, 4'd0, 0, 0, 10'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d, expected 0", state);
    end
  endtask

  task automatic test_redirect();
    stim_t s[$];
    logic [9:0] e;
    cur_vaddr = 39'h12_3456_789A;
    cur_operand = 71'({$urandom(), $urandom(), $urandom()});
    s.push_back(mk(0, 1, 4'd0, 0, 0, Y | RD | PO));
    s.push_back(mk(0, 0, 4'd0, 0, 0, 10'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL redirect[%0d]: got %b, expected %b", i, obs, e);
      end
      if (e & RD) begin
        vectors++;
        if (redirect_pc !== 39'h12_3456_789A) begin
          miscompares++;
          $display("FAIL redirect_pc: got %h, expected 12_3456_789a", redirect_pc);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [9:0] e;
    cur_vaddr = 39'({$urandom(), $urandom()});
    cur_operand = 71'({$urandom(), $urandom(), $urandom()});
    s.push_back(mk(0, 1, 4'd1, 0, 0, Y | IT));
    s.push_back(mk(0, 1, 4'd3, 0, 0, Y | AT));
    s.push_back(mk(0, 1, 4'd7, 0, 0, Y | IL));
    for (int k = 0; k < 5; k++) s.push_back(mk(0, 1, 4'($urandom_range(15, 5)), 0, 0, Y | IL));
    s.push_back(mk(0, 0, 4'd1, 0, 0, 10'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL b2b[%0d] op%0d: got %b, expected %b", i, s[i].op, obs, e);
      end
      if (e & IT) begin
        vectors++;
        if (itlb_w_vtag !== cur_vaddr[38:12] || itlb_w_entry !== cur_operand) begin
          miscompares++;
          $display("FAIL itlb_data: got %h/%h, expected %h/%h",
                   itlb_w_vtag, itlb_w_entry, cur_vaddr[38:12], cur_operand);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fence();
    stim_t s[$];
    logic [9:0] e;
    s.push_back(mk(0, 1, 4'd2, 0, 0, PO));
    s.push_back(mk(0, 1, 4'd2, 0, 0, FV | BZ));
    s.push_back(mk(0, 1, 4'd2, 0, 1, FV | BZ)); // done is ignored before acceptance
    s.push_back(mk(0, 1, 4'd2, 1, 0, FV | BZ));
    for (int k = 0; k < 4; k++) s.push_back(mk(0, 1, 4'd2, 0, 0, BZ));
    s.push_back(mk(0, 1, 4'd2, 0, 1, Y | BZ));
    s.push_back(mk(0, 0, 4'd0, 0, 0, 10'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL fence[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fence_timeout();
    stim_t s[$];
    logic [9:0] e;
    s.push_back(mk(0, 1, 4'd2, 0, 0, PO));
    s.push_back(mk(0, 1, 4'd2, 1, 0, FV | BZ));
    for (int k = 0; k < FT - 1; k++) s.push_back(mk(0, 1, 4'd2, 0, 0, BZ));
    s.push_back(mk(0, 1, 4'd2, 0, 0, Y | BZ));
    s.push_back(mk(0, 0, 4'd0, 0, 0, TO));
    s.push_back(mk(0, 1, 4'd0, 0, 0, Y | RD | PO | TO));
    s.push_back(mk(0, 0, 4'd0, 0, 0, TO));
    s.push_back(mk(1, 0, 4'd0, 0, 0, 10'h0));
    s.push_back(mk(0, 0, 4'd0, 0, 0, 10'h0));
    // done landing on the timeout cycle takes priority
    s.push_back(mk(0, 1, 4'd2, 0, 0, PO));
    s.push_back(mk(0, 1, 4'd2, 1, 0, FV | BZ));
    for (int k = 0; k < FT - 1; k++) s.push_back(mk(0, 1, 4'd2, 0, 0, BZ));
    s.push_back(mk(0, 1, 4'd2, 0, 1, Y | BZ));
    s.push_back(mk(0, 0, 4'd0, 0, 0, 10'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL fence_timeout[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_state_reset();
    stim_t s[$];
    logic [9:0] e;
    s.push_back(mk(0, 1, 4'd4, 0, 0, PO));
    for (int k = 0; k < RC - 1; k++) s.push_back(mk(0, 1, 4'd4, 0, 1, SR | BZ));
    s.push_back(mk(0, 1, 4'd4, 0, 0, Y | SR | BZ));
    s.push_back(mk(0, 0, 4'd0, 0, 0, 10'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL state_reset[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    stim_t s[$];
    logic [9:0] e;
    s.push_back(mk(0, 1, 4'd2, 0, 0, PO));
    s.push_back(mk(0, 1, 4'd2, 1, 0, FV | BZ));
    s.push_back(mk(0, 1, 4'd2, 0, 0, BZ));
    s.push_back(mk(0, 1, 4'd2, 0, 0, BZ));
    s.push_back(mk(1, 1, 4'd2, 0, 1, 10'h0));
    s.push_back(mk(0, 1, 4'd2, 0, 0, PO));       // same command decoded again
    s.push_back(mk(0, 1, 4'd2, 1, 0, FV | BZ));
    s.push_back(mk(0, 1, 4'd2, 0, 1, Y | BZ));
    s.push_back(mk(0, 1, 4'd4, 0, 0, PO));
    s.push_back(mk(0, 1, 4'd4, 0, 0, SR | BZ));
    s.push_back(mk(1, 1, 4'd4, 0, 0, 10'h0));
    s.push_back(mk(0, 1, 4'd4, 0, 0, PO));
    for (int k = 0; k < RC - 1; k++) s.push_back(mk(0, 1, 4'd4, 0, 0, SR | BZ));
    s.push_back(mk(0, 1, 4'd4, 0, 0, Y | SR | BZ));
    s.push_back(mk(0, 0, 4'd0, 0, 0, 10'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_abort[%0d]: got %b, expected %b", i, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.fe_cmd_v_i = 1'b0;
    bus.fe_cmd_i = '0;
    bus.icache_fence_ready_i = 1'b0;
    bus.icache_fence_done_i = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_redirect();
    test_back_to_back();
    test_fence();
    test_fence_timeout();
    test_state_reset();
    test_reset_abort();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
